// File: rtl/cpu_mc_pkg.sv
// ============================================================================
// Module : cpu_mc_pkg
// Brief  : Shared opcode/state encodings and constants for the cpu_mc core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mc_pkg;

  localparam int PC_IDX  = 15;
  localparam int MR_IDX  = 14;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_ADDI = 4'h9,
    OP_BZ   = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LOAD   = 3'd3,
    S_STORE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_mc_if.sv
// ============================================================================
// Module : cpu_mc_if
// Brief  : System bus between the cpu_mc master and its memory/peripherals.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_mc_if
  import cpu_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [INSTR_W-1:0]    bus_wrdata;
  logic [INSTR_W-1:0]    bus_rddata;
  logic                  bus_cyc;
  logic                  bus_write;
  logic                  bus_ack;

  modport master (
    output bus_addr, bus_wrdata, bus_cyc, bus_write,
    input  bus_rddata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wrdata, bus_cyc, bus_write,
    output bus_rddata, bus_ack
  );
endinterface

`default_nettype wire

// File: rtl/cpu_mc_alu.sv
// ============================================================================
// Module : cpu_mc_alu
// Brief  : Combinational ALU for register-register ops and ADDI, plus the
//          zero test of operand a used by BZ.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic [3:0]           op,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic [3:0]           imm4,
  output logic [REG_WIDTH-1:0] y,
  output logic                 a_zero
);

  assign a_zero = (a == '0);

  // Result select; unused opcodes give zero and are never written back.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADDI: y = a + REG_WIDTH'(imm4);
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_mc.sv
// ============================================================================
// Module : cpu_mc
// Brief  : Multi-cycle 16-bit-instruction CPU core, single bus master with
//          ack handshake and bus timeout. R15 is the PC, R14 the memory pointer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int REG_WIDTH  = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic     clk,
  input  logic     rst,
  cpu_mc_if.master bus,
  output logic     halted,
  output logic     retire,
  output logic     illegal_op,
  output logic     bus_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                r_state;
  state_t                w_next;
  logic [REG_WIDTH-1:0]  r_regs [16];
  logic [INSTR_W-1:0]    r_instr;
  logic [TW-1:0]         r_tcnt;
  logic                  r_tmo;

  logic [3:0]            w_opc, w_rd, w_ra, w_rb;
  logic [REG_WIDTH-1:0]  w_ra_val, w_rb_val, w_rd_val, w_alu_y;
  logic                  w_a_zero;
  logic                  w_expire;

  logic                  w_cyc, w_write, w_retire, w_illegal, w_tmo;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [INSTR_W-1:0]    w_wrdata;
  logic                  w_fetch_done;
  logic                  w_wr_en;
  logic [3:0]            w_wr_idx;
  logic [REG_WIDTH-1:0]  w_wr_data;

  assign w_opc    = r_instr[15:12];
  assign w_rd     = r_instr[11:8];
  assign w_ra     = r_instr[7:4];
  assign w_rb     = r_instr[3:0];
  assign w_ra_val = r_regs[w_ra];
  assign w_rb_val = r_regs[w_rb];
  assign w_rd_val = r_regs[w_rd];

  // Timeout fires on the TIMEOUT-th cycle of a transaction that is still unacked.
  assign w_expire = (TIMEOUT != 0) && (r_tcnt == c_TLAST);

  cpu_mc_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .op     (w_opc),
    .a      (w_ra_val),
    .b      (w_rb_val),
    .imm4   (w_rb),
    .y      (w_alu_y),
    .a_zero (w_a_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next state, bus drive, pulses and register write-back selection.
  // Everything is forced low while rst is asserted so cyc drops at once.
  always_comb begin
    w_next       = r_state;
    w_cyc        = 1'b0;
    w_write      = 1'b0;
    w_addr       = '0;
    w_wrdata     = '0;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    w_tmo        = 1'b0;
    w_fetch_done = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = w_rd;
    w_wr_data    = w_alu_y;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          w_cyc  = 1'b1;
          w_addr = r_regs[PC_IDX][ADDR_WIDTH-1:0];
          if (bus.bus_ack) begin
            w_fetch_done = 1'b1;
            w_next       = S_DECODE;
          end else if (w_expire) begin
            w_tmo  = 1'b1;
            w_next = S_HALT;
          end
        end
        S_DECODE: begin
          case (w_opc)
            OP_NOP: begin
              w_retire = 1'b1;
              w_next   = S_FETCH;
            end
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_BZ:
              w_next = S_EXEC;
            OP_LD:   w_next = S_LOAD;
            OP_ST:   w_next = S_STORE;
            OP_HALT: w_next = S_HALT;
            default: begin
              w_illegal = 1'b1;
              w_retire  = 1'b1;
              w_next    = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
          case (w_opc)
            OP_LDI: begin
              w_wr_en   = 1'b1;
              w_wr_data = {{(REG_WIDTH-8){1'b0}}, r_instr[7:0]};
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI:
              w_wr_en = 1'b1;
            OP_BZ: begin
              w_wr_en   = w_a_zero;
              w_wr_idx  = 4'(PC_IDX);
              w_wr_data = w_rd_val;
            end
            default: w_wr_en = 1'b0;
          endcase
        end
        S_LOAD: begin
          w_cyc  = 1'b1;
          w_addr = r_regs[MR_IDX][ADDR_WIDTH-1:0];
          if (bus.bus_ack) begin
            w_wr_en   = 1'b1;
            w_wr_data = {{(REG_WIDTH-16){1'b0}}, bus.bus_rddata};
            w_retire  = 1'b1;
            w_next    = S_FETCH;
          end else if (w_expire) begin
            w_tmo  = 1'b1;
            w_next = S_HALT;
          end
        end
        S_STORE: begin
          w_cyc    = 1'b1;
          w_write  = 1'b1;
          w_addr   = r_regs[MR_IDX][ADDR_WIDTH-1:0];
          w_wrdata = w_rd_val[15:0];
          if (bus.bus_ack) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else if (w_expire) begin
            w_tmo  = 1'b1;
            w_next = S_HALT;
          end
        end
        S_HALT:  w_next = S_HALT;
        default: w_next = S_HALT;
      endcase
    end
  end

  // Register file, instruction latch; PC increments on fetch, any later write to R15 jumps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_instr <= '0;
    end else begin
      if (w_fetch_done) begin
        r_instr        <= bus.bus_rddata;
        r_regs[PC_IDX] <= r_regs[PC_IDX] + REG_WIDTH'(1);
      end
      if (w_wr_en) r_regs[w_wr_idx] <= w_wr_data;
    end
  end

  // Counts unacked bus cycles of the current transaction; cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_tmo <= w_tmo;
      if (w_cyc && !bus.bus_ack) r_tcnt <= r_tcnt + TW'(1);
      else                       r_tcnt <= '0;
    end
  end

  assign bus.bus_cyc    = w_cyc;
  assign bus.bus_write  = w_write;
  assign bus.bus_addr   = w_addr;
  assign bus.bus_wrdata = w_wrdata;
  assign halted         = (r_state == S_HALT) && !rst;
  assign retire         = w_retire;
  assign illegal_op     = w_illegal;
  assign bus_timeout    = r_tmo && !rst;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mc.sv
// ============================================================================
// Module : tb_cpu_mc
// Brief  : Directed self-checking bench for cpu_mc with a wait-state memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted, retire, illegal_op, bus_timeout;

  cpu_mc_if #(.ADDR_WIDTH(14)) bif ();

  cpu_mc #(.ADDR_WIDTH(14), .REG_WIDTH(32), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .halted      (halted),
    .retire      (retire),
    .illegal_op  (illegal_op),
    .bus_timeout (bus_timeout)
  );

  always #5 clk = ~clk;

  // Memory model: addresses 0x10..0x3F are the data region with wait states.
  logic [15:0] mem [256];
  int          waits;
  bit          noack;
  int          wcnt;
  logic        in_data;

  assign in_data        = (bif.bus_addr[7:0] >= 8'h10) && (bif.bus_addr[7:0] < 8'h40);
  assign bif.bus_rddata = mem[bif.bus_addr[7:0]];
  assign bif.bus_ack    = bif.bus_cyc && !(noack && in_data) &&
                          (wcnt >= (in_data ? waits : 0));

  // Wait-state counter per transaction.
  always @(posedge clk) begin
    if (!bif.bus_cyc || bif.bus_ack) wcnt <= 0;
    else                             wcnt <= wcnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  int          k, t3, n_ret, n_ill, n_tmo, n_watch, n_wr;
  logic [31:0] wr_addr, wr_data;
  logic [13:0] watch;
  logic [31:0] rlog [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    waits = 0;
    noack = 1'b0;
    watch = 14'h3FFF;
  endtask

  task automatic start();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    k = 0; t3 = 0; n_ret = 0; n_ill = 0; n_tmo = 0; n_watch = 0; n_wr = 0;
    wr_addr = '0; wr_data = '0;
    rlog.delete();
    #1 rst = 1'b0;
  endtask

  // One cycle: sample outputs mid-cycle and perform memory writes.
  task automatic step();
    @(negedge clk);
    k++;
    if (retire) begin
      n_ret++;
      if (n_ret == 3 && t3 == 0) t3 = k;
    end
    if (illegal_op)  n_ill++;
    if (bus_timeout) n_tmo++;
    if (bif.bus_cyc && bif.bus_addr == watch) n_watch++;
    if (bif.bus_cyc && bif.bus_ack && !bif.bus_write) rlog.push_back(32'(bif.bus_addr));
    if (bif.bus_cyc && bif.bus_ack && bif.bus_write) begin
      n_wr++;
      wr_addr = 32'(bif.bus_addr);
      wr_data = 32'(bif.bus_wrdata);
      mem[bif.bus_addr[7:0]] = bif.bus_wrdata;
    end
  endtask

  task automatic run_to_halt(input int maxc);
    int i;
    i = 0;
    while (!halted && i < maxc) begin
      step();
      i++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    int a;
    clear_mem();

    // Reset state
    @(posedge clk); #1;
    chk("rst_cyc",    32'(bif.bus_cyc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc",     dut.r_regs[15], 32'd0);

    // LDI R1,5; LDI R2,3; SUB R3,R1,R2; HALT
    clear_mem();
    mem[0] = 16'h1105; mem[1] = 16'h1203; mem[2] = 16'h3312; mem[3] = 16'hF000;
    start();
    run_to_halt(60);
    chk("alu_r1",      dut.r_regs[1], 32'd5);
    chk("alu_r3",      dut.r_regs[3], 32'd2);
    chk("alu_retires", 32'(n_ret), 32'd3);
    chk("alu_cycles",  32'(t3), 32'd9);

    // LD with 4 wait states
    clear_mem();
    waits = 4; watch = 14'h20;
    mem[0] = 16'h1E20; mem[1] = 16'h7600; mem[2] = 16'hF000; mem[8'h20] = 16'hBEEF;
    start();
    run_to_halt(60);
    chk("ld_r6",      dut.r_regs[6], 32'h0000BEEF);
    chk("ld_cyc_len", 32'(n_watch), 32'd5);
    chk("ld_retires", 32'(n_ret), 32'd2);

    // ST R5=0x12345678 to 0x10, program jumped to 0x40 via write to R15
    clear_mem();
    waits = 2;
    mem[0] = 16'h1F40;
    a = 8'h40;
    mem[a++] = 16'h1512;
    for (int j = 0; j < 3; j++) begin
      for (int s = 0; s < 8; s++) mem[a++] = 16'h2555;
      mem[a++] = (j == 0) ? 16'h1634 : (j == 1) ? 16'h1656 : 16'h1678;
      mem[a++] = 16'h5556;
    end
    mem[a++] = 16'h1E10; mem[a++] = 16'h8500; mem[a++] = 16'hF000;
    start();
    run_to_halt(400);
    chk("st_r5",     dut.r_regs[5], 32'h12345678);
    chk("st_writes", 32'(n_wr), 32'd1);
    chk("st_addr",   wr_addr, 32'h10);
    chk("st_data",   wr_data, 32'h5678);
    chk("st_mem",    32'(mem[8'h10]), 32'h5678);

    // BZ taken: R2=0, R4=0x40
    clear_mem();
    mem[0] = 16'h1440; mem[1] = 16'hA420; mem[2] = 16'hF000;
    mem[8'h40] = 16'h1777; mem[8'h41] = 16'hF000;
    start();
    run_to_halt(60);
    chk("bz_t_fetch", (rlog.size() > 2) ? rlog[2] : 32'hDEAD, 32'h40);
    chk("bz_t_r7",    dut.r_regs[7], 32'h77);

    // BZ not taken: R2=1
    clear_mem();
    mem[0] = 16'h1201; mem[1] = 16'h1440; mem[2] = 16'hA420;
    mem[3] = 16'h1733; mem[4] = 16'hF000; mem[8'h40] = 16'h1777; mem[8'h41] = 16'hF000;
    start();
    run_to_halt(60);
    chk("bz_n_fetch", (rlog.size() > 3) ? rlog[3] : 32'hDEAD, 32'h3);
    chk("bz_n_r7",    dut.r_regs[7], 32'h33);

    // Illegal opcode 0xC executes as NOP
    clear_mem();
    mem[0] = 16'hC100; mem[1] = 16'h1109; mem[2] = 16'hF000;
    start();
    run_to_halt(60);
    chk("ill_pulses",  32'(n_ill), 32'd1);
    chk("ill_retires", 32'(n_ret), 32'd2);
    chk("ill_r1",      dut.r_regs[1], 32'd9);

    // Slave never acks the data access: timeout after 8 cycles
    clear_mem();
    noack = 1'b1; watch = 14'h30;
    mem[0] = 16'h11AA; mem[1] = 16'h1E30; mem[2] = 16'h7200; mem[3] = 16'hF000;
    mem[8'h30] = 16'h5555;
    start();
    run_to_halt(60);
    chk("tmo_cyc_len", 32'(n_watch), 32'd8);
    chk("tmo_pulse",   32'(n_tmo), 32'd1);
    chk("tmo_r2",      dut.r_regs[2], 32'd0);
    chk("tmo_r1",      dut.r_regs[1], 32'hAA);
    step();
    chk("tmo_pulse_end", 32'(bus_timeout), 32'd0);
    chk("tmo_cyc_off",   32'(bif.bus_cyc), 32'd0);
    chk("tmo_halted",    32'(halted), 32'd1);

    // Asynchronous reset in the middle of a waiting LOAD
    clear_mem();
    waits = 4;
    mem[0] = 16'h1E20; mem[1] = 16'h7300; mem[2] = 16'hF000; mem[8'h20] = 16'h1234;
    start();
    a = 0;
    while (!(bif.bus_cyc && bif.bus_addr == 14'h20) && a < 30) begin
      step();
      a++;
    end
    chk("mid_ld_seen", 32'(bif.bus_cyc && bif.bus_addr == 14'h20), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc",  32'(bif.bus_cyc), 32'd0);
    chk("mid_rst_addr", 32'(bif.bus_addr), 32'd0);
    chk("mid_rst_r14",  dut.r_regs[14], 32'd0);
    chk("mid_rst_pc",   dut.r_regs[15], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    step();
    chk("mid_refetch_cyc",  32'(bif.bus_cyc), 32'd1);
    chk("mid_refetch_addr", 32'(bif.bus_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
